bip_control: RTL and testbench
==============================

// Module: bip_control
// PURPOSE
//  Multi-cycle control unit (sequencer) for the BIP 16-bit accumulator processor.
//  Fetches instructions from program memory, decodes the 5-bit opcode and 11-bit operand,
//  and drives the datapath: accumulator mux/write, ALU add/sub, data-memory read/write.
//  Sits between the program ROM, the data RAM and the accumulator datapath inside bip.
// PARAMETERS
//  PC_W     11  program counter / operand width (memory depth 2**PC_W)
//  OPC_W    5   opcode width; instr = {opcode[15:11], operand[10:0]}
//  INSTR_W  16  instruction width
//  CNT_W    16  retired-instruction counter width
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        synchronous, active-high
//  enable       in   1        1 = run; 0 = hold in FETCH before next instruction
//  instr_addr   out  PC_W     program memory address (= pc)
//  instr_rd     out  1        program memory read strobe (sync ROM, data valid next cycle)
//  instr_data   in   INSTR_W  program memory read data
//  data_addr    out  PC_W     data memory address (= operand)
//  data_rd      out  1        data memory read strobe (sync RAM, data valid next cycle)
//  data_wr      out  1        data memory write strobe (datapath writes acc)
//  operand      out  PC_W     operand field of IR, to datapath sign-extender
//  sel_a        out  2        acc input mux: 00 mem, 01 sign-ext imm, 10 ALU result
//  sel_b        out  1        ALU B operand: 0 mem, 1 sign-ext imm
//  op_sub       out  1        ALU op: 0 add (acc+B), 1 subtract (acc-B)
//  wr_acc       out  1        accumulator write enable (one-cycle pulse)
//  halted       out  1        1 while in HALT
//  retired      out  1        one-cycle pulse per completed non-HLT instruction
//  retired_cnt  out  CNT_W    retired-instruction count, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset: state=FETCH, pc=0, ir=0, retired_cnt=0; all strobes, wr_acc, halted, retired = 0;
//   sel_a=00, sel_b=0, op_sub=0. Reset wins over every other event, in any state.
//  Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI,
//   00110 SUB, 00111 SUBI; all others = NOP.
//  States: FETCH -> DECODE -> EXEC [-> MEM] -> FETCH; HALT is absorbing until reset.
//   FETCH : if enable: instr_rd=1, instr_addr=pc, go DECODE; else stay, no strobes.
//   DECODE: ir <= instr_data; go EXEC. enable is ignored once FETCH has left.
//   EXEC  : HLT -> HALT, pc unchanged, no retired pulse.
//           STO -> data_wr=1, data_addr=operand; pc+1; retired; go FETCH.
//           LDI -> sel_a=01, wr_acc=1. ADDI/SUBI -> sel_a=10, sel_b=1, op_sub=SUBI.
//             Each: pc+1, retired, go FETCH.
//           LD/ADD/SUB -> data_rd=1, data_addr=operand; go MEM.
//           NOP -> pc+1, retired, go FETCH.
//   MEM   : LD -> sel_a=00. ADD/SUB -> sel_a=10, sel_b=0, op_sub=SUB. wr_acc=1, pc+1,
//           retired; go FETCH.
//   HALT  : halted=1; no strobes; pc frozen.
//  Latency: STO/immediate/NOP = 3 cycles; LD/ADD/SUB = 4 cycles (FETCH to FETCH).
//  Pulses: wr_acc, data_wr, data_rd, instr_rd, retired are high for exactly one cycle.
//   sel_a, sel_b, op_sub are valid whenever wr_acc=1 and are don't-care otherwise.
//  pc increments modulo 2**PC_W; 2**PC_W-1 wraps to 0.
//  retired_cnt increments together with the retired pulse and wraps.
//  data_addr and operand hold ir[PC_W-1:0] continuously.
// TESTING
//  1. reset held 2 cycles, then LDI 5; HLT -> wr_acc in cycle 3 (sel_a=01, operand=5),
//     halted=1 from cycle 6, pc=1, retired_cnt=1.
//  2. LD 3; ADD 4; SUB 5; HLT, with mem[3]=10, mem[4]=7, mem[5]=2 -> acc=15;
//     data_rd pulses at addresses 3, 4, 5; each instruction takes 4 cycles; retired_cnt=3.
//  3. LDI 9; STO 20; HLT -> data_wr pulse with data_addr=20 in the 6th cycle after reset.
//  4. enable=0 after reset for 5 cycles -> no instr_rd, pc=0.
//     Deassert enable during DECODE -> current instruction completes, then holds in FETCH.
//  5. pc preset to 2047 via NOP fill, executing NOP at 2047 -> next instr_addr=0.
//     Undefined opcode 11111 -> retired pulse, no wr_acc/data_wr.
//  6. Assert reset during MEM and during HALT -> next cycle state=FETCH, pc=0,
//     halted=0, no wr_acc.

Source files
------------

// File: rtl/bip_control.sv
// bip_control: multi-cycle sequencer for the BIP 16-bit accumulator CPU.
// Fetches from a sync ROM, decodes and drives the accumulator datapath.
module bip_control #(
    parameter int PC_W    = 11,
    parameter int OPC_W   = 5,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [PC_W-1:0]    instr_addr,
    output logic               instr_rd,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    data_addr,
    output logic               data_rd,
    output logic               data_wr,
    output logic [PC_W-1:0]    operand,
    output logic [1:0]         sel_a,
    output logic               sel_b,
    output logic               op_sub,
    output logic               wr_acc,
    output logic               halted,
    output logic               retired,
    output logic [CNT_W-1:0]   retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

    localparam logic [1:0] SEL_MEM = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [OPC_W-1:0]   opcode;
    logic [PC_W-1:0]    pc_inc;

    assign opcode      = ir_q[INSTR_W-1 -: OPC_W];
    assign pc_inc      = pc_q + PC_W'(1);
    assign instr_addr  = pc_q;
    assign data_addr   = ir_q[PC_W-1:0];
    assign operand     = ir_q[PC_W-1:0];
    assign retired_cnt = cnt_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        instr_rd = 1'b0;
        data_rd  = 1'b0;
        data_wr  = 1'b0;
        sel_a    = SEL_MEM;
        sel_b    = 1'b0;
        op_sub   = 1'b0;
        wr_acc   = 1'b0;
        halted   = 1'b0;
        retired  = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (enable) begin
                    instr_rd = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                ir_d    = instr_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                retired = 1'b1;
                case (opcode)
                    OP_HLT: begin
                        // halted rises as soon as HLT is recognised
                        state_d = S_HALT;
                        pc_d    = pc_q;
                        retired = 1'b0;
                        halted  = 1'b1;
                    end
                    OP_STO: data_wr = 1'b1;
                    OP_LDI: begin
                        sel_a  = SEL_IMM;
                        wr_acc = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_a  = SEL_ALU;
                        sel_b  = 1'b1;
                        op_sub = (opcode == OP_SUBI);
                        wr_acc = 1'b1;
                    end
                    OP_LD, OP_ADD, OP_SUB: begin
                        data_rd = 1'b1;
                        state_d = S_MEM;
                        pc_d    = pc_q;
                        retired = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                sel_a   = (opcode == OP_LD) ? SEL_MEM : SEL_ALU;
                op_sub  = (opcode == OP_SUB);
                wr_acc  = 1'b1;
                retired = 1'b1;
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // reset silences every strobe in the cycle it is asserted
        if (reset) begin
            instr_rd = 1'b0;
            data_rd  = 1'b0;
            data_wr  = 1'b0;
            sel_a    = SEL_MEM;
            sel_b    = 1'b0;
            op_sub   = 1'b0;
            wr_acc   = 1'b0;
            halted   = 1'b0;
            retired  = 1'b0;
        end
    end

    assign cnt_d = cnt_q + CNT_W'(retired);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: lockstep check of bip_control against an ISA-level
// model with instruction latencies, plus a small ROM/RAM/acc datapath.
module tb_bip_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] instr_addr, data_addr, operand;
    logic        instr_rd, data_rd, data_wr;
    logic [15:0] instr_data = 16'h0;
    logic [1:0]  sel_a;
    logic        sel_b, op_sub, wr_acc, halted, retired;
    logic [15:0] retired_cnt;

    bip_control dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .instr_addr  (instr_addr),
        .instr_rd    (instr_rd),
        .instr_data  (instr_data),
        .data_addr   (data_addr),
        .data_rd     (data_rd),
        .data_wr     (data_wr),
        .operand     (operand),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .op_sub      (op_sub),
        .wr_acc      (wr_acc),
        .halted      (halted),
        .retired     (retired),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom   [2048];
    logic [15:0] ram   [2048];
    logic [15:0] m_mem [2048];
    logic [15:0] acc   = 16'h0;
    logic [15:0] ram_q = 16'h0;

    // ISA-level reference state
    logic [10:0] m_pc   = '0;
    logic [15:0] m_ir   = '0;
    logic [15:0] m_acc  = '0;
    logic [15:0] m_cnt  = '0;
    bit          m_halt = 0;
    int          m_k    = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ins(input int op, input int opd);
        logic [4:0]  o;
        logic [10:0] d;
        o = op[4:0];
        d = opd[10:0];
        return {o, d};
    endfunction

    function automatic logic [15:0] sx(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    task automatic step(input logic en, input logic rst);
        logic [4:0]  op;
        logic [10:0] opd;
        bit          is_mem;
        int          lat;
        logic        e_ird, e_drd, e_dwr, e_wacc, e_ret, e_halt;
        logic        c_ird, c_drd, c_dwr, c_wacc, c_sb, c_sub;
        logic [10:0] c_ia, c_da, c_opd;
        logic [1:0]  c_sa;
        logic [15:0] b, nxt;

        @(negedge clk);
        enable = en;
        reset  = rst;
        #1;
        op     = m_ir[15:11];
        opd    = m_ir[10:0];
        is_mem = (op == 2) || (op == 4) || (op == 6);
        lat    = is_mem ? 4 : 3;
        e_ird = 0; e_drd = 0; e_dwr = 0; e_wacc = 0; e_ret = 0; e_halt = 0;
        if (!rst) begin
            if (m_halt) e_halt = 1;
            else if (m_k == 0) e_ird = en;
            else if (m_k == 2) begin
                e_drd  = is_mem;
                e_dwr  = (op == 1);
                e_wacc = (op == 3) || (op == 5) || (op == 7);
                e_halt = (op == 0);
                e_ret  = !is_mem && (op != 0);
            end else if (m_k == 3) begin
                e_wacc = 1;
                e_ret  = 1;
            end
        end
        c_ird = instr_rd; c_ia = instr_addr; c_drd = data_rd;
        c_dwr = data_wr;  c_da = data_addr;  c_wacc = wr_acc;
        c_opd = operand;  c_sa = sel_a; c_sb = sel_b; c_sub = op_sub;

        check("instr_rd", c_ird, e_ird);
        check("data_rd", c_drd, e_drd);
        check("data_wr", c_dwr, e_dwr);
        check("wr_acc", c_wacc, e_wacc);
        check("retired", retired, e_ret);
        check("halted", halted, e_halt);
        check("retired_cnt", retired_cnt, m_cnt);
        check("acc", acc, m_acc);
        if (e_ird) check("instr_addr", c_ia, m_pc);
        if (!rst && !m_halt && m_k >= 2) check("operand", c_opd, opd);
        if (e_drd || e_dwr) check("data_addr", c_da, opd);
        if (e_wacc) begin
            check("sel_a", c_sa, (op == 2) ? 2'b00 : (op == 3) ? 2'b01 : 2'b10);
            if (op >= 4) begin
                check("sel_b", c_sb, (op == 5) || (op == 7));
                check("op_sub", c_sub, (op == 6) || (op == 7));
            end
        end

        @(posedge clk);
        // datapath reacting to the controls seen before the edge
        if (c_ird) instr_data <= rom[c_ia];
        b   = c_sb ? sx(c_opd) : ram_q;
        nxt = (c_sa == 2'b00) ? ram_q : (c_sa == 2'b01) ? sx(c_opd)
            : (c_sub ? acc - b : acc + b);
        if (c_dwr) ram[c_da] = acc;
        if (c_drd) ram_q = ram[c_da];
        if (c_wacc) acc = nxt;

        if (rst) begin
            m_pc = '0; m_k = 0; m_halt = 0; m_cnt = '0; m_ir = '0;
        end else if (m_halt) begin
        end else if (m_k == 0) begin
            if (en) begin
                m_ir = rom[m_pc];
                m_k  = 1;
            end
        end else if (m_k < lat - 1) begin
            m_k++;
        end else if (op == 0) begin
            m_halt = 1;
        end else begin
            case (op)
                1: m_mem[opd] = m_acc;
                2: m_acc = m_mem[opd];
                3: m_acc = sx(opd);
                4: m_acc = m_acc + m_mem[opd];
                5: m_acc = m_acc + sx(opd);
                6: m_acc = m_acc - m_mem[opd];
                7: m_acc = m_acc - sx(opd);
                default: ;
            endcase
            m_pc++;
            m_cnt++;
            m_k = 0;
        end
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 2048; i++) rom[i] = ins(8, i);
    endtask

    task automatic set_mem(input int a, input logic [15:0] v);
        ram[a]   = v;
        m_mem[a] = v;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) set_mem(i, 16'($urandom));
        fill_nop();

        // LDI 5; HLT
        rom[0] = ins(3, 5);
        rom[1] = ins(0, 0);
        step(0, 1);
        step(0, 1);
        repeat (10) step(1, 0);
        #2;
        check("t1_cnt", retired_cnt, 1);
        check("t1_halted", halted, 1);
        check("t1_pc", instr_addr, 1);
        check("t1_acc", acc, 5);

        // LD 3; ADD 4; SUB 5; HLT
        rom[0] = ins(2, 3); rom[1] = ins(4, 4);
        rom[2] = ins(6, 5); rom[3] = ins(0, 0);
        set_mem(3, 10); set_mem(4, 7); set_mem(5, 2);
        step(0, 1);
        step(0, 1);
        repeat (16) step(1, 0);
        #2;
        check("t2_acc", acc, 15);
        check("t2_cnt", retired_cnt, 3);

        // LDI 9; STO 20; HLT
        rom[0] = ins(3, 9); rom[1] = ins(1, 20); rom[2] = ins(0, 0);
        step(0, 1);
        repeat (10) step(1, 0);
        #2;
        check("t3_mem20", ram[20], 9);

        // enable low after reset, then dropped during DECODE
        rom[0] = ins(3, 5); rom[1] = ins(3, 6); rom[2] = ins(0, 0);
        step(0, 1);
        repeat (5) step(0, 0);
        #2;
        check("t4_pc", instr_addr, 0);
        check("t4_cnt0", retired_cnt, 0);
        step(1, 0);
        repeat (7) step(0, 0);
        #2;
        check("t4_cnt1", retired_cnt, 1);
        check("t4_hold_pc", instr_addr, 1);
        check("t4_acc", acc, 5);

        // 2048 NOPs (one undefined opcode) wrap pc to 0
        fill_nop();
        rom[100] = ins(31, 3);
        step(0, 1);
        repeat (2048 * 3) step(1, 0);
        #2;
        check("t5_wrap_pc", instr_addr, 0);
        check("t5_cnt", retired_cnt, 2048);

        // reset during MEM, then during HALT
        rom[0] = ins(2, 3); rom[1] = ins(0, 0);
        step(0, 1);
        repeat (3) step(1, 0);
        step(1, 1);
        #2;
        check("t6_mem_halted", halted, 0);
        check("t6_mem_pc", instr_addr, 0);
        check("t6_mem_wracc", wr_acc, 0);
        repeat (10) step(1, 0);
        #2;
        check("t6_halt_reached", halted, 1);
        step(1, 1);
        #2;
        check("t6_halt_halted", halted, 0);
        check("t6_halt_pc", instr_addr, 0);
        check("t6_halt_cnt", retired_cnt, 0);

        // random programs, random enable and occasional reset
        repeat (25) begin
            for (int i = 0; i < 2048; i++) begin
                int r;
                r = $urandom_range(0, 31);
                if (r < 2) rom[i] = ins(0, 0);
                else if (r < 26) rom[i] = ins(1 + (r % 7), $urandom_range(0, 2047));
                else rom[i] = ins($urandom_range(8, 31), $urandom_range(0, 2047));
            end
            step(0, 1);
            repeat (300) step($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
